vga_timing: RTL
===============

# vga_timing

Raster timing generator for the elevator-simulator VGA display. Divides the system clock down to a pixel rate. Sweeps horizontal and vertical counters over a full 640x480 frame, including the blanking regions, and drives the monitor sync pulses. Sits directly upstream of the pixel generator, supplying its `x_coord`, `y_coord` and `enable` inputs. Also provides frame and line markers plus a slow animation tick for the simulation logic.

## Interface
Parameters:
- `PIX_DIV`, 2: system clocks per pixel; legal range 1–16.
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `ANIM_FRAMES`, 30: frames per `anim_tick` pulse; legal range 1–255.

Ports:
- `clk`, in, 1: system clock.
- `n_rst`, in, 1: synchronous, active-low reset.
- `x_coord`, out, 10: current horizontal count, 0..H_TOTAL-1.
- `y_coord`, out, 10: current vertical count, 0..V_TOTAL-1.
- `enable`, out, 1: high when `x_coord < H_ACTIVE` and `y_coord < V_ACTIVE`.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `pix_tick`, out, 1: one-clock strobe marking the clock on which the counters advance.
- `line_start`, out, 1: one-clock pulse when `x_coord` wraps to 0.
- `frame_start`, out, 1: one-clock pulse when (x,y) wraps to (0,0).
- `anim_tick`, out, 1: one-clock pulse on every ANIM_FRAMES-th `frame_start`.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, default 800.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP, default 525.
  - Both must be ≤ 1024; elaboration fails otherwise.
- Pixel divider:
  - `div_cnt` counts 0..PIX_DIV-1 and then wraps.
  - The internal tick is asserted when `div_cnt == PIX_DIV-1`.
  - With PIX_DIV=1 the tick is asserted every clock.
- Counter advance, on the clock edge where the tick is asserted:
  - `x_coord` increments.
  - At H_TOTAL-1, `x_coord` wraps to 0 and `y_coord` increments.
  - At V_TOTAL-1, `y_coord` wraps to 0.
- Sync windows:
  - `hsync` = 0 iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - `vsync` = 0 iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC (default 490..491).
- Animation counter:
  - 8-bit `frame_cnt` increments on each `frame_start`.
  - On the `frame_start` where `frame_cnt == ANIM_FRAMES-1`, `frame_cnt` wraps to 0 and `anim_tick` fires in the same cycle.
- All outputs are registered:
  - `enable`, `hsync` and `vsync` are decoded from the next-state counter values, so they always match the `x_coord`/`y_coord` presented in the same cycle.
  - No combinational path from counters to outputs.
- Reset (`n_rst` low at a clock edge) forces:
  - `div_cnt` = 0, x = 0, y = 0, `frame_cnt` = 0.
  - `enable` = 1, `hsync` = 1, `vsync` = 1.
  - `pix_tick`, `line_start`, `frame_start`, `anim_tick` = 0.
  - Reset overrides any tick in the same cycle. Applies equally mid-line or mid-frame; no partial state survives.

## Timing
- After reset deasserts, the first counter advance happens on the PIX_DIV-th rising edge. Outputs hold their reset values until then.
- Between ticks every output is stable for exactly PIX_DIV clocks.
- `pix_tick`, `line_start`, `frame_start` and `anim_tick` each last exactly one clock. They are high in the cycle when the new coordinate values are first presented.
- Simultaneous events: on the frame wrap, `line_start`, `frame_start` and, when due, `anim_tick` all assert in the same cycle.
- Pixel and frame counts at defaults:
  - One line = 800 pixel ticks.
  - One frame = 420000 pixel ticks = 840000 clocks at PIX_DIV=2.

## Test plan
- Reset, and reset with PIX_DIV=1:
  - Stimulus: hold `n_rst` low for 3 clocks (default parameters), then release.
    - Required response: x=0, y=0, `enable`=1, `hsync`=1, `vsync`=1, all pulse outputs 0.
    - Required response: x becomes 1 on the 2nd edge after release and 2 on the 4th.
  - Stimulus: repeat with PIX_DIV=1.
    - Required response: x increments on every edge.
- Line sweep (PIX_DIV=2):
  - `enable` falls exactly when x goes 639→640.
  - `hsync` is low for x=656..751, i.e. 96 ticks = 192 clocks.
  - x goes 799→0 with y 0→1 and a single-clock `line_start`.
- Frame wrap:
  - At (799,524) the next tick gives (0,0) with `frame_start`=1 and `line_start`=1 for one clock.
  - `vsync` is low only for y=490..491, i.e. 1600 ticks.
  - `frame_start` pulses are 420000 ticks apart.
- Animation (ANIM_FRAMES=3):
  - `anim_tick` pulses coincident with the 3rd, 6th and 9th `frame_start` only.
- Mid-frame reset:
  - Stimulus: drive `n_rst` low for one clock at (300,200) with a tick pending.
  - Required response: next cycle shows full reset values; first advance again occurs PIX_DIV edges after release.
  - Required response: the next `anim_tick` comes ANIM_FRAMES frames later.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, horizontal/vertical sweep,
// sync decode and line/frame/animation markers. Every output is registered.
module vga_timing #(
  parameter int PIX_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int ANIM_FRAMES = 30
) (
  input  logic       clk,
  input  logic       n_rst,
  output logic [9:0] x_coord,
  output logic [9:0] y_coord,
  output logic       enable,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_tick,
  output logic       line_start,
  output logic       frame_start,
  output logic       anim_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = VS_LO + V_SYNC;

  localparam logic [3:0] DIV_LAST  = 4'(PIX_DIV - 1);
  localparam logic [9:0] X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [7:0] ANIM_LAST = 8'(ANIM_FRAMES - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
      $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
      $error("vga_timing: PIX_DIV must be in 1..16");
    end
    if (ANIM_FRAMES < 1 || ANIM_FRAMES > 255) begin : g_bad_anim
      $error("vga_timing: ANIM_FRAMES must be in 1..255");
    end
  endgenerate

  function automatic logic in_window(input logic [9:0] v, input int lo, input int hi);
    int vi;
    vi = int'({22'd0, v});
    in_window = (vi >= lo) && (vi < hi);
  endfunction

  logic [3:0] div_cnt;
  logic [7:0] frame_cnt;
  logic       tick;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       wrap_frame;

  // Next-state counter values; only committed on a tick.
  always_comb begin
    tick  = (div_cnt == DIV_LAST);
    x_nxt = x_coord + 10'd1;
    y_nxt = y_coord;
    if (x_coord == X_LAST) begin
      x_nxt = '0;
      y_nxt = (y_coord == Y_LAST) ? '0 : y_coord + 10'd1;
    end
    wrap_frame = (x_nxt == '0) && (y_nxt == '0);
  end

  // Output register stage: decodes use next-state values so they line up
  // with the coordinates presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      div_cnt     <= '0;
      x_coord     <= '0;
      y_coord     <= '0;
      frame_cnt   <= '0;
      enable      <= 1'b1;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      pix_tick    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      anim_tick   <= 1'b0;
    end else begin
      div_cnt     <= tick ? 4'd0 : div_cnt + 4'd1;
      pix_tick    <= tick;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      anim_tick   <= 1'b0;
      if (tick) begin
        x_coord     <= x_nxt;
        y_coord     <= y_nxt;
        enable      <= in_window(x_nxt, 0, H_ACTIVE) && in_window(y_nxt, 0, V_ACTIVE);
        hsync       <= !in_window(x_nxt, HS_LO, HS_HI);
        vsync       <= !in_window(y_nxt, VS_LO, VS_HI);
        line_start  <= (x_nxt == '0);
        frame_start <= wrap_frame;
        if (wrap_frame) begin
          if (frame_cnt == ANIM_LAST) begin
            frame_cnt <= '0;
            anim_tick <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule
